sm83_alu_seq: RTL and testbench
===============================

SM83_ALU_SEQ -- requirements
Module: sm83_alu_seq

Interface
REQ-001 SHALL have parameter LOGIC_OPS_DEFAULT_ERR, default 1, meaning error flag value reported for logic opcodes when SM83_ALU_SEQ_LOGIC_EN is undefined.
REQ-002 SHALL have ports: clk in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-003 SHALL have ports: start in 1, request; op in 3, 0 ADD / 1 ADC / 2 SUB / 3 SBC / 4 AND / 5 XOR / 6 OR / 7 CP; a in 8, operand A; b in 8, operand B; c_in in 1, current C flag.
REQ-004 SHALL have ports: busy out 1; done out 1, one-cycle completion pulse; err out 1; result out 8; flag_z, flag_n, flag_h, flag_c out 1 each.
REQ-005 SHALL have ALU-control ports (all out): alu_din 8, alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, alu_negate, alu_carry_in, alu_no_carry_out (R), alu_force_carry (S), alu_ignore_carry (V), all 1 except alu_din.
REQ-006 SHALL have ALU-status inputs: alu_dout in 8, alu_carry in 1, alu_zero in 1.

Function
REQ-007 SHALL be a posedge FSM: IDLE, LDA, LDB, LO, HI, DONE; every ALU-control output registered.
REQ-008 SHALL leave IDLE only on start=1, latching op, a, b, c_in; start is ignored in every other state.
REQ-009 LDA: alu_din=a, alu_shift_oe=1, alu_load_a=1 (ALU captures on following negedge); next LDB.
REQ-010 LDB: alu_din=b, alu_shift_oe=1, alu_load_b=1; next LO.
REQ-011 LO: alu_result_oe=1, alu_op_low=1, alu_op_b_high=0; at exit posedge, latch alu_carry as internal half-carry hc; next HI.
REQ-012 HI: alu_result_oe=1, alu_op_low=0, alu_op_b_high=1, alu_carry_in=hc for arithmetic ops; at exit posedge, capture alu_dout, alu_carry, alu_zero; next DONE.
REQ-013 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in LDA through DONE inclusive; start-to-done latency 5 cycles.
REQ-014 Control mapping (R,S,V,negate,LO carry_in): ADD 0,0,0,0,0; ADC 0,0,0,0,c_in; SUB/CP 0,0,0,1,1; SBC 0,0,0,1,!c_in; AND 0,1,0,0,1 (HI carry_in=1); XOR 1,0,0,0,0; OR 1,0,1,0,0 (HI carry_in=0 for XOR/OR).
REQ-015 Flags: flag_z=alu_zero from HI; ADD/ADC: N=0, H=hc, C=alu_carry; SUB/SBC/CP: N=1, H=!hc, C=!alu_carry; AND: N=0,H=1,C=0; XOR/OR: N=0,H=0,C=0.
REQ-016 result SHALL update at DONE entry for all ops except CP; CP updates flags only, result holds prior value.
REQ-017 err SHALL be 0 on every successful operation; result and flags hold between operations.
REQ-018 alu_din SHALL be 0 and all ALU strobes 0 outside LDA/LDB/LO/HI; at most one *_oe high per cycle.

Reset
REQ-019 reset_n=0 SHALL asynchronously force IDLE, busy=0, done=0, err=0, result=0x00, all flags 0, hc=0, all ALU-control outputs 0, including mid-operation; aborted operation produces no done.
REQ-020 ALU operand registers are not reset; sequencer SHALL reload both operands on every operation.

Configuration
REQ-021 Macro SM83_ALU_SEQ_LOGIC_EN defined: ops 4-6 execute per REQ-014/015.
REQ-022 Macro undefined: ops 4-6 go IDLE->DONE directly (latency 1), no ALU strobes, err=LOGIC_OPS_DEFAULT_ERR, result and flags unchanged.

Verification
REQ-023 ADD a=0x3A b=0xC6 -> done 5 cycles after start, result 0x00, Z=1 N=0 H=1 C=1.
REQ-024 SUB a=0x10 b=0x01 -> result 0x0F, Z=0 N=1 H=1 C=0; CP a=0x42 b=0x42 -> Z=1 N=1 C=0, result unchanged.
REQ-025 SBC a=0x00 b=0x00 c_in=1 -> result 0xFF, Z=0 N=1 H=1 C=1.
REQ-026 AND a=0xF0 b=0x3C with macro -> 0x30, H=1 N=0 C=0; without macro -> done after 1 cycle, err=1, result unchanged.
REQ-027 start pulsed while busy -> ignored, single done; reset_n low during LO -> all outputs 0 immediately, no done, next start runs normally.

Source files
------------

// File: rtl/sm83_alu_seq.sv
// sm83_alu_seq: drives an external nibble-serial SM83 ALU through load A, load B, low and high nibble passes, then reports result and flags.
// Latency: start-to-done 5 cycles; logic ops (AND/XOR/OR) take 1 cycle and return err when SM83_ALU_SEQ_LOGIC_EN is undefined.
// Backpressure: none; start is accepted only in IDLE and ignored while busy; done pulses for exactly one cycle.
module sm83_alu_seq #(
  parameter bit LOGIC_OPS_DEFAULT_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] result,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h,
  output logic       flag_c,
  output logic [7:0] alu_din,
  output logic       alu_load_a,
  output logic       alu_load_b,
  output logic       alu_shift_oe,
  output logic       alu_result_oe,
  output logic       alu_op_low,
  output logic       alu_op_b_high,
  output logic       alu_negate,
  output logic       alu_carry_in,
  output logic       alu_no_carry_out,
  output logic       alu_force_carry,
  output logic       alu_ignore_carry,
  input  logic [7:0] alu_dout,
  input  logic       alu_carry,
  input  logic       alu_zero
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_LO   = 3'd3,
    S_HI   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic       hc_q, hc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] result_q, result_d;
  logic       z_q, z_d, n_q, n_d, h_q, h_d, c_q, c_d;
  logic [7:0] din_q, din_d;
  logic       load_a_q, load_a_d, load_b_q, load_b_d;
  logic       shift_oe_q, shift_oe_d, result_oe_q, result_oe_d;
  logic       op_low_q, op_low_d, op_b_high_q, op_b_high_d;
  logic       negate_q, negate_d, carry_in_q, carry_in_d;
  logic       r_q, r_d, s_q, s_d, v_q, v_d;

  // {R, S, V, negate} ALU mode bits for an opcode; CP shares SUB's datapath.
  function automatic logic [3:0] op_mode(input logic [2:0] o);
    case (o)
      OP_SUB, OP_SBC, OP_CP: op_mode = 4'b0001;
      OP_AND:                op_mode = 4'b0100;
      OP_XOR:                op_mode = 4'b1000;
      OP_OR:                 op_mode = 4'b1010;
      default:               op_mode = 4'b0000;
    endcase
  endfunction

  // Carry into the low-nibble pass; subtraction is A + ~B + 1, with borrow-in inverting that carry.
  function automatic logic lo_cin(input logic [2:0] o, input logic c);
    case (o)
      OP_ADC:                lo_cin = c;
      OP_SUB, OP_CP, OP_AND: lo_cin = 1'b1;
      OP_SBC:                lo_cin = ~c;
      default:               lo_cin = 1'b0;
    endcase
  endfunction

  // Carry into the high-nibble pass; arithmetic ops chain the half-carry from the low pass.
  function automatic logic hi_cin(input logic [2:0] o, input logic hc);
    case (o)
      OP_AND:        hi_cin = 1'b1;
      OP_XOR, OP_OR: hi_cin = 1'b0;
      default:       hi_cin = hc;
    endcase
  endfunction

  // Next-state, datapath capture and registered control outputs for the state being entered.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    hc_d     = hc_q;
    err_d    = err_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    h_d      = h_q;
    c_d      = c_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          a_d   = a;
          b_d   = b;
          cin_d = c_in;
`ifdef SM83_ALU_SEQ_LOGIC_EN
          state_d = S_LDA;
`else
          // Without logic-op support these complete at once, leaving result and flags untouched.
          if (op == OP_AND || op == OP_XOR || op == OP_OR) begin
            state_d = S_DONE;
            err_d   = LOGIC_OPS_DEFAULT_ERR;
          end else begin
            state_d = S_LDA;
          end
`endif
        end
      end
      S_LDA: state_d = S_LDB;
      S_LDB: state_d = S_LO;
      S_LO: begin
        hc_d    = alu_carry;
        state_d = S_HI;
      end
      S_HI: begin
        state_d = S_DONE;
        err_d   = 1'b0;
        z_d     = alu_zero;
        if (op_q != OP_CP) result_d = alu_dout;
        case (op_q)
          OP_ADD, OP_ADC: begin
            n_d = 1'b0; h_d = hc_q;  c_d = alu_carry;
          end
          OP_SUB, OP_SBC, OP_CP: begin
            n_d = 1'b1; h_d = ~hc_q; c_d = ~alu_carry;
          end
          OP_AND: begin
            n_d = 1'b0; h_d = 1'b1;  c_d = 1'b0;
          end
          default: begin
            n_d = 1'b0; h_d = 1'b0;  c_d = 1'b0;
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    din_d       = 8'h00;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    shift_oe_d  = 1'b0;
    result_oe_d = 1'b0;
    op_low_d    = 1'b0;
    op_b_high_d = 1'b0;
    negate_d    = 1'b0;
    carry_in_d  = 1'b0;
    r_d         = 1'b0;
    s_d         = 1'b0;
    v_d         = 1'b0;

    case (state_d)
      S_LDA: begin
        din_d = a_d; shift_oe_d = 1'b1; load_a_d = 1'b1;
      end
      S_LDB: begin
        din_d = b_q; shift_oe_d = 1'b1; load_b_d = 1'b1;
      end
      S_LO: begin
        result_oe_d = 1'b1;
        op_low_d    = 1'b1;
        {r_d, s_d, v_d, negate_d} = op_mode(op_q);
        carry_in_d  = lo_cin(op_q, cin_q);
      end
      S_HI: begin
        result_oe_d = 1'b1;
        op_b_high_d = 1'b1;
        {r_d, s_d, v_d, negate_d} = op_mode(op_q);
        // hc_d is the carry being latched on this edge, so HI sees it in its first cycle.
        carry_in_d  = hi_cin(op_q, hc_d);
      end
      default: ;
    endcase
  end

  // State, datapath and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      cin_q       <= 1'b0;
      hc_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= 8'h00;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      h_q         <= 1'b0;
      c_q         <= 1'b0;
      din_q       <= 8'h00;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      shift_oe_q  <= 1'b0;
      result_oe_q <= 1'b0;
      op_low_q    <= 1'b0;
      op_b_high_q <= 1'b0;
      negate_q    <= 1'b0;
      carry_in_q  <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      hc_q        <= hc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      z_q         <= z_d;
      n_q         <= n_d;
      h_q         <= h_d;
      c_q         <= c_d;
      din_q       <= din_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      shift_oe_q  <= shift_oe_d;
      result_oe_q <= result_oe_d;
      op_low_q    <= op_low_d;
      op_b_high_q <= op_b_high_d;
      negate_q    <= negate_d;
      carry_in_q  <= carry_in_d;
      r_q         <= r_d;
      s_q         <= s_d;
      v_q         <= v_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign result           = result_q;
  assign flag_z           = z_q;
  assign flag_n           = n_q;
  assign flag_h           = h_q;
  assign flag_c           = c_q;
  assign alu_din          = din_q;
  assign alu_load_a       = load_a_q;
  assign alu_load_b       = load_b_q;
  assign alu_shift_oe     = shift_oe_q;
  assign alu_result_oe    = result_oe_q;
  assign alu_op_low       = op_low_q;
  assign alu_op_b_high    = op_b_high_q;
  assign alu_negate       = negate_q;
  assign alu_carry_in     = carry_in_q;
  assign alu_no_carry_out = r_q;
  assign alu_force_carry  = s_q;
  assign alu_ignore_carry = v_q;

endmodule

// File: tb/tb_sm83_alu_seq.sv
// tb_sm83_alu_seq: table-driven scoreboard bench for sm83_alu_seq with a behavioural nibble-serial ALU attached.
// Expected results are pushed on each start and popped when done pulses; latency is measured per operation.
// Hand sequences cover start-while-busy, reset in the middle of an operation, and the idle strobe rules.
module tb_sm83_alu_seq;

`ifdef SM83_ALU_SEQ_LOGIC_EN
  localparam bit LOGIC_EN = 1'b1;
`else
  localparam bit LOGIC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       c_in;
  logic       busy, done, err;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_h, flag_c;
  logic [7:0] alu_din;
  logic       alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high;
  logic       alu_negate, alu_carry_in, alu_no_carry_out, alu_force_carry, alu_ignore_carry;
  logic [7:0] alu_dout;
  logic       alu_carry, alu_zero;

  sm83_alu_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .err(err), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_h(flag_h), .flag_c(flag_c),
    .alu_din(alu_din), .alu_load_a(alu_load_a), .alu_load_b(alu_load_b),
    .alu_shift_oe(alu_shift_oe), .alu_result_oe(alu_result_oe), .alu_op_low(alu_op_low),
    .alu_op_b_high(alu_op_b_high), .alu_negate(alu_negate), .alu_carry_in(alu_carry_in),
    .alu_no_carry_out(alu_no_carry_out), .alu_force_carry(alu_force_carry),
    .alu_ignore_carry(alu_ignore_carry),
    .alu_dout(alu_dout), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Behavioural external ALU: operand latches on negedge, one nibble per pass.
  logic [7:0] alu_a_q = 8'h00, alu_b_q = 8'h00;
  logic [3:0] lo_res_q = 4'h0;
  logic [3:0] an, bn, bx, nib;
  logic [4:0] sum;

  always_comb begin
    an  = alu_op_low    ? alu_a_q[3:0] : alu_a_q[7:4];
    bn  = alu_op_b_high ? alu_b_q[7:4] : alu_b_q[3:0];
    bx  = alu_negate ? ~bn : bn;
    sum = {1'b0, an} + {1'b0, bx} + {4'h0, alu_carry_in};
    if (alu_no_carry_out && alu_ignore_carry) nib = an | bn;
    else if (alu_no_carry_out)                nib = an ^ bn;
    else if (alu_force_carry)                 nib = an & bn;
    else                                      nib = sum[3:0];
    alu_carry = sum[4];
    alu_dout  = 8'h00;
    if (alu_result_oe) alu_dout = alu_op_low ? {4'h0, nib} : {nib, lo_res_q};
    alu_zero  = alu_result_oe && !alu_op_low && (alu_dout == 8'h00);
  end

  always @(negedge clk) begin
    if (alu_load_a) alu_a_q <= alu_din;
    if (alu_load_b) alu_b_q <= alu_din;
    if (alu_result_oe && alu_op_low) lo_res_q <= nib;
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [3:0] fl;   // {Z, N, H, C}
  } vec_t;

  typedef struct {
    int         id;
    int         t0;
    int         lat;
    logic [7:0] res;
    logic [3:0] fl;
    logic       err;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  exp_t sb [$];

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         done_seen = 0;
  logic [7:0] prev_res = 8'h00;
  logic [3:0] prev_fl = 4'h0;

  wire [10:0] strobes = {alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe, alu_op_low,
                         alu_op_b_high, alu_negate, alu_carry_in, alu_no_carry_out,
                         alu_force_carry, alu_ignore_carry};
  wire [33:0] all_out = {busy, done, err, result, flag_z, flag_n, flag_h, flag_c, alu_din, strobes};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: strobe rules every cycle, scoreboard comparison on every done pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("one_oe", {alu_shift_oe, alu_result_oe} == 2'b11, 1'b0);
      if (!busy || done) chk("quiet_ctl", {alu_din, strobes}, 0);
      if (done) begin
        done_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("v%0d result", e.id), result, e.res);
          chk($sformatf("v%0d flags_znhc", e.id), {flag_z, flag_n, flag_h, flag_c}, e.fl);
          chk($sformatf("v%0d err", e.id), err, e.err);
          chk($sformatf("v%0d latency", e.id), cyc - e.t0, e.lat);
        end
      end
    end
  end

  // Expected outcome of a vector given the bench's record of held result/flags.
  function automatic exp_t make_exp(input int id, input vec_t v);
    exp_t e;
    logic is_logic;
    is_logic = (v.op == 3'd4) || (v.op == 3'd5) || (v.op == 3'd6);
    e.id = id;
    e.t0 = cyc;
    if (is_logic && !LOGIC_EN) begin
      e.res = prev_res; e.fl = prev_fl; e.err = 1'b1; e.lat = 1;
    end else begin
      e.res = (v.op == 3'd7) ? prev_res : v.res;
      e.fl = v.fl; e.err = 1'b0; e.lat = 5;
    end
    return e;
  endfunction

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk({name, " timeout"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_op(input int id, input vec_t v);
    exp_t e;
    @(posedge clk); #1;
    e = make_exp(id, v);
    prev_res = e.res;
    prev_fl  = e.fl;
    sb.push_back(e);
    start = 1'b1; op = v.op; a = v.a; b = v.b; c_in = v.cin;
    @(posedge clk); #1;
    // Scramble inputs so any late sampling shows up.
    start = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
    wait_empty($sformatf("v%0d", id));
  endtask

  initial begin
    //             op    a      b      cin   res    ZNHC
    vecs[0]  = '{3'd0, 8'h3A, 8'hC6, 1'b0, 8'h00, 4'b1011};  // ADD
    vecs[1]  = '{3'd2, 8'h10, 8'h01, 1'b0, 8'h0F, 4'b0110};  // SUB
    vecs[2]  = '{3'd7, 8'h42, 8'h42, 1'b0, 8'h00, 4'b1100};  // CP equal
    vecs[3]  = '{3'd3, 8'h00, 8'h00, 1'b1, 8'hFF, 4'b0111};  // SBC borrow
    vecs[4]  = '{3'd1, 8'h0F, 8'h00, 1'b1, 8'h10, 4'b0010};  // ADC half carry
    vecs[5]  = '{3'd0, 8'h12, 8'h34, 1'b0, 8'h46, 4'b0000};  // ADD plain
    vecs[6]  = '{3'd2, 8'h05, 8'h07, 1'b0, 8'hFE, 4'b0111};  // SUB negative
    vecs[7]  = '{3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1011};  // ADC wrap
    vecs[8]  = '{3'd3, 8'h20, 8'h10, 1'b0, 8'h10, 4'b0100};  // SBC no borrow
    vecs[9]  = '{3'd7, 8'h10, 8'h20, 1'b1, 8'h00, 4'b0101};  // CP less
    vecs[10] = '{3'd4, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0010};  // AND
    vecs[11] = '{3'd5, 8'hFF, 8'h0F, 1'b0, 8'hF0, 4'b0000};  // XOR
    vecs[12] = '{3'd6, 8'h00, 8'h00, 1'b1, 8'h00, 4'b1000};  // OR zero
    vecs[13] = '{3'd4, 8'h0F, 8'hF0, 1'b0, 8'h00, 4'b1010};  // AND zero
    vecs[14] = '{3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b1000};  // ADD zero

    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_out, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", all_out, 0);

    for (int i = 0; i < NV; i++) run_op(i, vecs[i]);

    // Start held/pulsed while busy: only one operation, control sequence as expected.
    begin
      exp_t e;
      @(posedge clk); #1;
      e = make_exp(100, vecs[5]);
      prev_res = e.res; prev_fl = e.fl;
      sb.push_back(e);
      start = 1'b1; op = 3'd0; a = 8'h12; b = 8'h34; c_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; op = 3'd2; a = 8'hFF; b = 8'hFF;
      chk("lda_busy", busy, 1'b1);
      chk("lda_ctl", {alu_din, alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe}, {8'h12, 4'b1010});
      @(posedge clk); #1;
      start = 1'b1;
      chk("ldb_ctl", {alu_din, alu_load_a, alu_load_b, alu_shift_oe, alu_result_oe}, {8'h34, 4'b0110});
      @(posedge clk); #1;
      chk("lo_ctl", {alu_din, alu_shift_oe, alu_result_oe, alu_op_low, alu_op_b_high, alu_carry_in}, {8'h00, 5'b01100});
      @(posedge clk); #1;
      start = 1'b0;
      chk("hi_ctl", {alu_result_oe, alu_op_low, alu_op_b_high, alu_carry_in, alu_negate}, 5'b10100);
      wait_empty("busy_start");
      repeat (6) @(posedge clk);
    end

    // Reset asserted during the low-nibble pass aborts silently.
    begin
      exp_t e;
      int   seen;
      @(posedge clk); #1;
      e = make_exp(200, vecs[1]);
      sb.push_back(e);
      start = 1'b1; op = 3'd2; a = 8'h10; b = 8'h01; c_in = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_in_lo", {alu_result_oe, alu_op_low}, 2'b11);
      seen = done_seen;
      reset_n = 1'b0;
      #1;
      chk("abort_outputs", all_out, 0);
      sb.delete();
      prev_res = 8'h00; prev_fl = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("abort_no_done", done_seen, seen);
      run_op(201, vecs[3]);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
